// File: rtl/agg_pkg.sv
// ---------------------------------------------------------------------------
// agg_pkg
// Shared definitions for the aggregator stream path: row-size shift, FSM
// state encodings used by the unpacker, and the rows_of() helper that turns
// a header LENGTH into the number of payload rows that follow it.
// Ports: none (package).
// ---------------------------------------------------------------------------
package agg_pkg;

    // Each payload row carries 8 length units, hence a shift of 3.
    localparam int ROW_SHIFT = 3;

    // Native LENGTH width the helper operates on.
    localparam int AGG_LEN_W = 32;

    // Unpacker FSM encodings.
    localparam logic [1:0] HDR     = 2'd0;
    localparam logic [1:0] PAYLOAD = 2'd1;
    localparam logic [1:0] DROP    = 2'd2;

    // Row count is one wider than LENGTH so the +1 can never wrap to zero.
    function automatic logic [AGG_LEN_W:0] rows_of(input logic [AGG_LEN_W-1:0] len);
        return (AGG_LEN_W+1)'(len >> ROW_SHIFT) + (AGG_LEN_W+1)'(1);
    endfunction

endpackage

// File: rtl/agg_skid_buf.sv
// ---------------------------------------------------------------------------
// agg_skid_buf
// Two-entry valid/ready buffer. Entry slot0 is always the head and drives
// pop_data directly, so a word pushed into an empty buffer is visible on the
// following cycle.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   push_data/valid   write side; caller only pushes when the buffer has room
//   pop_data/ready    read side; pop happens when ready and not empty
//   count, full, empty occupancy status
// ---------------------------------------------------------------------------
module agg_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_valid,
    output logic [WIDTH-1:0] pop_data,
    input  logic             pop_ready,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign pop_data = slot0;
    assign do_pop   = pop_ready && !empty;
    // A push into a full buffer is never legal, even alongside a pop.
    assign do_push  = push_valid && !full;

    // Shift-style storage: pops move slot1 into the head, pushes land in the
    // first free slot (or the head when it is being vacated this cycle).
    always_ff @(posedge clk) begin
        if (reset) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (empty) begin
                        slot0 <= push_data;
                    end else begin
                        slot1 <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/agg_stream_unpacker.sv
// ---------------------------------------------------------------------------
// agg_stream_unpacker
// Parses the aggregator's framed stream (one header word whose low LEN_W bits
// hold LENGTH, then rows_of(LENGTH) payload rows), strips the header and
// re-emits the rows with sop/eop/len sideband through a 2-entry skid buffer.
// Packets with LENGTH > MAX_LEN are consumed silently with an err_len pulse.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   in_data/in_valid/in_ready     upstream framed stream
//   out_data/out_valid/out_ready  downstream payload rows
//   out_sop/out_eop/out_len       per-row packet sideband
//   pkt_count                     packets fully delivered downstream (wraps)
//   err_len                       one-cycle pulse per oversize header
// ---------------------------------------------------------------------------
module agg_stream_unpacker
    import agg_pkg::*;
#(
    parameter int DATA_W  = 256,
    parameter int LEN_W   = 32,
    parameter int MAX_LEN = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [LEN_W-1:0]  out_len,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              err_len
);

    localparam int BUF_W = DATA_W + 2 + LEN_W;

    logic [1:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   row_cnt;
    logic [LEN_W:0]   rows;
    logic             in_fire;
    logic             hdr_oversize;
    logic             last_row;
    logic             push_valid;
    logic [BUF_W-1:0] push_data;
    logic [BUF_W-1:0] pop_data;
    logic [1:0]       buf_count;
    logic             buf_full;
    logic             buf_empty;

    assign rows = (LEN_W+1)'(rows_of(AGG_LEN_W'(len_q)));

    // DROP discards words, so it never needs buffer space; everything else
    // waits for a free entry. Held low while reset is asserted.
    assign in_ready     = !reset && ((state == DROP) || (buf_count < 2'd2));
    assign in_fire      = in_valid && in_ready;
    assign hdr_oversize = in_data[LEN_W-1:0] > LEN_W'(MAX_LEN);
    assign last_row     = (row_cnt == rows);

    assign push_valid = in_fire && (state == PAYLOAD) && !buf_full;
    assign push_data  = {in_data, (row_cnt == (LEN_W+1)'(1)), last_row, len_q};

    assign out_valid = !buf_empty;
    assign {out_data, out_sop, out_eop, out_len} = pop_data;

    agg_skid_buf #(
        .WIDTH (BUF_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .push_data  (push_data),
        .push_valid (push_valid),
        .pop_data   (pop_data),
        .pop_ready  (out_ready),
        .count      (buf_count),
        .full       (buf_full),
        .empty      (buf_empty)
    );

    // Framing FSM: advances only on accepted input words, so backpressure
    // stalls it without losing or repeating rows.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= HDR;
            len_q   <= '0;
            row_cnt <= '0;
            err_len <= 1'b0;
        end else begin
            err_len <= 1'b0;
            if (in_fire) begin
                case (state)
                    HDR: begin
                        len_q   <= in_data[LEN_W-1:0];
                        row_cnt <= (LEN_W+1)'(1);
                        if (hdr_oversize) begin
                            err_len <= 1'b1;
                            state   <= DROP;
                        end else begin
                            state   <= PAYLOAD;
                        end
                    end
                    PAYLOAD, DROP: begin
                        if (last_row) begin
                            state <= HDR;
                        end else begin
                            row_cnt <= row_cnt + (LEN_W+1)'(1);
                        end
                    end
                    default: begin
                        state <= HDR;
                    end
                endcase
            end
        end
    end

    // A packet counts as complete only once its eop row leaves downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (out_valid && out_ready && out_eop) begin
            pkt_count <= pkt_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_agg_stream_unpacker.sv
// ---------------------------------------------------------------------------
// tb_agg_stream_unpacker
// Directed bench for agg_stream_unpacker. Expected rows are derived from each
// packet's LENGTH with plain arithmetic and queued; a per-cycle compare
// process checks every accepted output row, output stability under stall and
// the packet counter. Hand-computed literals pin specific behaviours.
// pkt_count is built 8 bits wide here so the wrap is reached quickly.
// ---------------------------------------------------------------------------
module tb_agg_stream_unpacker;

    localparam int DW     = 256;
    localparam int LW     = 32;
    localparam int CW     = 8;
    localparam int MAXLEN = 1024;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [LW-1:0] len;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sop;
    logic          out_eop;
    logic [LW-1:0] out_len;
    logic [CW-1:0] pkt_count;
    logic          err_len;

    exp_t          expQ[$];
    int            errors = 0;
    int            checks = 0;
    int            cycle = 0;
    int            errCount = 0;
    int            expErr = 0;
    int            outMode = 0;
    int            modeStart = 0;
    logic          sawNotReady = 1'b0;
    logic [CW-1:0] modelPkt = '0;

    agg_stream_unpacker #(
        .DATA_W  (DW),
        .LEN_W   (LW),
        .MAX_LEN (MAXLEN),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_len   (out_len),
        .pkt_count (pkt_count),
        .err_len   (err_len)
    );

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    // Global safety net in case something stalls forever.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Downstream ready: always high, or the 1,0,0,1 pattern anchored at the
    // cycle the main sequence selected it.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (outMode == 1) begin
                out_ready = (((cycle - modeStart) % 4) == 0) || (((cycle - modeStart) % 4) == 3);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [DW-1:0] word);
        int waited;
        waited = 0;
        in_data  = word;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("in_accept_timeout", DW'(0), DW'(1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Queue the rows the packet must produce, then send header and rows.
    task automatic sendPacket(input logic [LW-1:0] len, input logic [DW-1:0] base);
        int   nRows;
        exp_t e;
        nRows = int'(len / 8) + 1;
        if (len <= MAXLEN) begin
            for (int k = 0; k < nRows; k++) begin
                e.data = base + DW'(k);
                e.sop  = (k == 0);
                e.eop  = (k == nRows - 1);
                e.len  = len;
                expQ.push_back(e);
            end
        end else begin
            expErr++;
        end
        applyStimulus({224'hC0FFEE, len});
        for (int k = 0; k < nRows; k++) begin
            applyStimulus(base + DW'(k));
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", DW'(expQ.size()), DW'(0));
        @(negedge clk);
    endtask

    // Per-cycle compare against the queued model.
    logic          stallValid = 1'b0;
    logic [DW-1:0] heldData;
    logic          heldSop;
    logic          heldEop;
    logic [LW-1:0] heldLen;
    logic          prevErr = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            modelPkt   = '0;
            stallValid = 1'b0;
            prevErr    = 1'b0;
        end else begin
            if (!in_ready) sawNotReady = 1'b1;
            if (err_len) begin
                errCount++;
                if (prevErr) checkOutput("err_len_single_pulse", DW'(1), DW'(0));
            end
            prevErr = err_len;
            checkOutput("pkt_count", DW'(pkt_count), DW'(modelPkt));
            if (stallValid) begin
                checkOutput("stall_valid", DW'(out_valid), DW'(1));
                checkOutput("stall_data", out_data, heldData);
                checkOutput("stall_side", DW'({out_sop, out_eop, out_len}),
                            DW'({heldSop, heldEop, heldLen}));
            end
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", out_data, DW'(0));
                end else if (out_ready) begin
                    e = expQ.pop_front();
                    checkOutput("row_data", out_data, e.data);
                    checkOutput("row_sop", DW'(out_sop), DW'(e.sop));
                    checkOutput("row_eop", DW'(out_eop), DW'(e.eop));
                    checkOutput("row_len", DW'(out_len), DW'(e.len));
                    if (e.eop) modelPkt = modelPkt + CW'(1);
                end
            end
            stallValid = out_valid && !out_ready;
            heldData   = out_data;
            heldSop    = out_sop;
            heldEop    = out_eop;
            heldLen    = out_len;
        end
    end

    initial begin
        exp_t e;
        int   startCycle;
        int   elapsed;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] checking reset state");
        checkOutput("reset_in_ready", DW'(in_ready), DW'(0));
        checkOutput("reset_out_valid", DW'(out_valid), DW'(0));
        checkOutput("reset_out_data", out_data, DW'(0));
        checkOutput("reset_side", DW'({out_sop, out_eop, out_len}), DW'(0));
        checkOutput("reset_pkt_count", DW'(pkt_count), DW'(0));
        checkOutput("reset_err_len", DW'(err_len), DW'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("in_ready_after_reset", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;

        $display("[TB] single-row packet LEN=5");
        sendPacket(32'd5, DW'(32'hA1));
        @(negedge clk);
        checkOutput("t1_valid_next_cycle", DW'(out_valid), DW'(1));
        checkOutput("t1_data", out_data, DW'(32'hA1));
        checkOutput("t1_sop_eop", DW'({out_sop, out_eop}), DW'(2'b11));
        checkOutput("t1_len", DW'(out_len), DW'(5));
        waitDrain();
        checkOutput("t1_pkt_count", DW'(pkt_count), DW'(1));
        @(posedge clk);
        #1;

        $display("[TB] three-row packet LEN=20");
        sendPacket(32'd20, DW'(32'h100));
        waitDrain();
        checkOutput("t2_pkt_count", DW'(pkt_count), DW'(2));
        @(posedge clk);
        #1;

        $display("[TB] three-row packet with toggling out_ready");
        sawNotReady = 1'b0;
        modeStart   = cycle;
        outMode     = 1;
        sendPacket(32'd20, DW'(32'h200));
        waitDrain();
        outMode = 0;
        checkOutput("t3_in_ready_dropped", DW'(sawNotReady), DW'(1));
        checkOutput("t3_pkt_count", DW'(pkt_count), DW'(3));
        @(posedge clk);
        #1;

        $display("[TB] oversize packet LEN=2000 then LEN=0");
        sendPacket(32'd2000, DW'(32'h3000));
        sendPacket(32'd0, DW'(32'h55));
        waitDrain();
        checkOutput("t4_err_pulses", DW'(errCount), DW'(1));
        checkOutput("t4_err_model", DW'(errCount), DW'(expErr));
        checkOutput("t4_pkt_count", DW'(pkt_count), DW'(4));
        @(posedge clk);
        #1;

        $display("[TB] reset in the middle of a packet");
        for (int k = 0; k < 2; k++) begin
            e.data = DW'(32'h400) + DW'(k);
            e.sop  = (k == 0);
            e.eop  = 1'b0;
            e.len  = 32'd20;
            expQ.push_back(e);
        end
        applyStimulus({224'hC0FFEE, 32'd20});
        applyStimulus(DW'(32'h400));
        applyStimulus(DW'(32'h401));
        repeat (3) @(negedge clk);
        checkOutput("t5_rows_before_reset", DW'(expQ.size()), DW'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        expQ.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("t5_reset_in_ready", DW'(in_ready), DW'(0));
        checkOutput("t5_reset_out_valid", DW'(out_valid), DW'(0));
        checkOutput("t5_reset_pkt_count", DW'(pkt_count), DW'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        sendPacket(32'd8, DW'(32'h800));
        waitDrain();
        checkOutput("t5_pkt_count", DW'(pkt_count), DW'(1));
        @(posedge clk);
        #1;

        $display("[TB] 256 back-to-back LEN=0 packets (counter wrap)");
        startCycle = cycle;
        for (int p = 0; p < 256; p++) begin
            sendPacket(32'd0, DW'(p + 32'h1000));
        end
        elapsed = cycle - startCycle;
        checkOutput("t6_throughput", DW'(elapsed <= 514), DW'(1));
        waitDrain();
        checkOutput("t6_pkt_count_wrapped", DW'(pkt_count), DW'(1));
        checkOutput("t6_no_new_err", DW'(errCount), DW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
